// File: rtl/sysinfo_pkg.sv
// sysinfo_pkg: register word addresses, CTRL bit positions and FSM states shared with firmware.
package sysinfo_pkg;
    localparam int DATA_W           = 32;
    localparam int SYSINFO_ID       = 0;
    localparam int SYSINFO_VERSION  = 1;
    localparam int SYSINFO_FEATURES = 2;
    localparam int SYSINFO_SCRATCH  = 3;
    localparam int SYSINFO_UPTIME_LO = 4;
    localparam int SYSINFO_UPTIME_HI = 5;
    localparam int SYSINFO_CTRL     = 6;
    localparam int CTRL_CLR         = 0;
    localparam int CTRL_SRST        = 1;
    typedef enum logic {SRST_IDLE, SRST_PULSE} srst_state_e;
endpackage

// File: rtl/sysinfo_uptime.sv
// sysinfo_uptime: free-running uptime counter with clear and a high-word snapshot for coherent 64-bit reads.
module sysinfo_uptime #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        snap_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-33:0] snap_q, snap_d;

    always_comb begin
        cnt_d  = clr_i ? '0 : cnt_q + 1'b1;
        snap_d = snap_i ? cnt_q[CNT_W-1:32] : snap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign lo_o = cnt_q[31:0];
    assign hi_o = 32'(snap_q);
endmodule

// File: rtl/sysinfo.sv
// sysinfo: native-bus system-information peripheral with ID/version/features, scratch, uptime and soft-reset request.
module sysinfo
    import sysinfo_pkg::*;
#(
    parameter logic [31:0] ID       = 32'h0,
    parameter logic [31:0] VERSION  = 32'h0,
    parameter logic [31:0] FEATURES = 32'h0,
    parameter int          ADDR_W   = 3,
    parameter int          CNT_W    = 64,
    parameter int          SRST_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              soft_rst_o
);
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    srst_state_e       state_q, state_d;
    logic [7:0]        srst_cnt_q, srst_cnt_d;
    logic              acc, wr, ctrl_wr, clr, srst, snap;
    logic [31:0]       up_lo, up_hi;

    assign acc     = valid & ~ready_q;
    assign wr      = |wstrb;
    assign ctrl_wr = acc & wr & wstrb[0] & (address == ADDR_W'(SYSINFO_CTRL));
    assign clr     = ctrl_wr & wdata[CTRL_CLR];
    assign srst    = ctrl_wr & wdata[CTRL_SRST];
    assign snap    = acc & ~wr & (address == ADDR_W'(SYSINFO_UPTIME_LO));

    sysinfo_uptime #(.CNT_W(CNT_W)) u_up (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .snap_i (snap),
        .lo_o   (up_lo),
        .hi_o   (up_hi)
    );

    always_comb begin
        case (address)
            ADDR_W'(SYSINFO_ID):        rd_mux = ID;
            ADDR_W'(SYSINFO_VERSION):   rd_mux = VERSION;
            ADDR_W'(SYSINFO_FEATURES):  rd_mux = FEATURES;
            ADDR_W'(SYSINFO_SCRATCH):   rd_mux = scratch_q;
            ADDR_W'(SYSINFO_UPTIME_LO): rd_mux = up_lo;
            ADDR_W'(SYSINFO_UPTIME_HI): rd_mux = up_hi;
            default:                    rd_mux = '0;
        endcase
        ready_d   = acc;
        rdata_d   = acc ? (wr ? '0 : rd_mux) : rdata_q;
        scratch_d = scratch_q;
        for (int i = 0; i < 4; i++)
            if (acc && wstrb[i] && address == ADDR_W'(SYSINFO_SCRATCH))
                scratch_d[8*i +: 8] = wdata[8*i +: 8];
    end

    // A bit1 write in PULSE reloads the counter, stretching the pulse.
    always_comb begin
        state_d    = state_q;
        srst_cnt_d = srst_cnt_q;
        if (srst) begin
            state_d    = SRST_PULSE;
            srst_cnt_d = 8'(SRST_CYC);
        end else if (state_q == SRST_PULSE) begin
            srst_cnt_d = srst_cnt_q - 8'd1;
            state_d    = (srst_cnt_q == 8'd1) ? SRST_IDLE : SRST_PULSE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            scratch_q  <= '0;
            state_q    <= SRST_IDLE;
            srst_cnt_q <= '0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            scratch_q  <= scratch_d;
            state_q    <= state_d;
            srst_cnt_q <= srst_cnt_d;
        end
    end

    assign ready      = ready_q;
    assign rdata      = rdata_q;
    assign soft_rst_o = (state_q == SRST_PULSE);
endmodule

// File: tb/tb_sysinfo.sv
// tb_sysinfo: scoreboard bench for sysinfo against a cycle-count-based reference model.
module tb_sysinfo;
    localparam logic [31:0] ID_V   = 32'hA5A5_0001;
    localparam logic [31:0] VER_V  = 32'h0002_0100;
    localparam logic [31:0] FEAT_V = 32'h0000_000F;
    localparam int CNT_W = 40;
    localparam longint unsigned MASK = (64'd1 << CNT_W) - 1;

    logic        clk = 0, rst = 1, valid = 0;
    logic [2:0]  address = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0]  wstrb = 0;
    logic        ready, soft_rst_o;

    int checks = 0, errors = 0;
    longint unsigned cyc = 0, org_cyc = 0, org_val = 0;
    logic [31:0] scratch_m = 0, snap_m = 0;
    logic [31:0] exp_q[$];
    logic [2:0]  adr_q[$];

    sysinfo #(.ID(ID_V), .VERSION(VER_V), .FEATURES(FEAT_V), .ADDR_W(3), .CNT_W(CNT_W), .SRST_CYC(16)) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .soft_rst_o(soft_rst_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint unsigned cnt_at(longint unsigned c);
        return (org_val + (c - org_cyc)) & MASK;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (ready) begin
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: got ready with nothing outstanding, expected none");
        end else begin
            logic [31:0] e;
            logic [2:0] a;
            e = exp_q.pop_front();
            a = adr_q.pop_front();
            check($sformatf("rdata@addr%0d", a), rdata, e);
        end
    end

    function automatic logic [31:0] predict(logic [2:0] a, logic [31:0] d, logic [3:0] s);
        longint unsigned v;
        if (s != 0) begin
            for (int i = 0; i < 4; i++) if (a == 3 && s[i]) scratch_m[8*i +: 8] = d[8*i +: 8];
            if (a == 6 && s[0] && d[0]) begin org_cyc = cyc + 1; org_val = 0; end
            return 32'h0;
        end
        case (a)
            0: return ID_V;
            1: return VER_V;
            2: return FEAT_V;
            3: return scratch_m;
            4: begin v = cnt_at(cyc); snap_m = 32'(v >> 32); return v[31:0]; end
            5: return snap_m;
            default: return 32'h0;
        endcase
    endfunction

    task automatic xfer(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        exp_q.push_back(predict(a, d, s));
        adr_q.push_back(a);
        address = a; wdata = d; wstrb = s; valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 10);
        if (!ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, expected ready", n);
            void'(exp_q.pop_back()); void'(adr_q.pop_back());
        end
        valid = 0; wstrb = 0;
    endtask

    task automatic pulse_len(input longint unsigned rise, input int exp_len);
        int n;
        n = 0;
        while (soft_rst_o && n < 100) begin @(negedge clk); n++; end
        check("soft_rst_len", 32'(cyc - rise), 32'(exp_len));
    endtask

    initial begin
        longint unsigned rise;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_soft", {31'b0, soft_rst_o}, 0);
        rst = 0; org_cyc = cyc; org_val = 0;

        xfer(0, 0, 0); xfer(1, 0, 0); xfer(2, 0, 0); xfer(7, 0, 0);
        xfer(3, 32'hDEADBEEF, 4'b1111); xfer(3, 32'h00000011, 4'b0001); xfer(3, 0, 0);
        check("scratch_model", scratch_m, 32'hDEADBE11);
        xfer(0, 32'h12345678, 4'b1111); xfer(0, 0, 0);
        xfer(4, 0, 0); xfer(5, 0, 0); xfer(6, 0, 0);

        @(negedge clk);
        force dut.u_up.cnt_q = 40'hFF_FFFF_FFF0;
        #1 release dut.u_up.cnt_q;
        org_cyc = cyc; org_val = 64'hFF_FFFF_FFF0;
        xfer(4, 0, 0);
        repeat (10) @(negedge clk);
        xfer(5, 0, 0);
        check("snap_hi_model", snap_m, 32'hFF);
        repeat (5) @(negedge clk);
        xfer(4, 0, 0); xfer(5, 0, 0);
        check("wrap_hi_model", snap_m, 32'h0);

        xfer(6, 32'h1, 4'b0001);
        @(negedge clk);
        xfer(4, 0, 0);
        check("clear_small", {31'b0, cnt_at(cyc) <= 4}, 1);

        xfer(6, 32'h2, 4'b0001);
        rise = cyc;
        pulse_len(rise, 16);
        xfer(6, 32'h2, 4'b0001);
        rise = cyc;
        repeat (8) @(negedge clk);
        xfer(6, 32'h2, 4'b0001);
        pulse_len(rise, 26);

        xfer(6, 32'h2, 4'b0001);
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        check("rst_mid_soft", {31'b0, soft_rst_o}, 0);
        check("rst_mid_ready", {31'b0, ready}, 0);
        @(negedge clk);
        rst = 0; org_cyc = cyc; org_val = 0; scratch_m = 0; snap_m = 0;
        xfer(3, 0, 0); xfer(5, 0, 0); xfer(4, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] a;
            logic [3:0] s;
            a = 3'($urandom_range(0, 7));
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            xfer(a, $urandom, s);
        end

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin exp_q.push_back(ID_V); adr_q.push_back(0); end
        address = 0; wstrb = 0; valid = 1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("hold_ready_%0d", i), {31'b0, ready}, {31'b0, i[0]});
            if (i < 5) @(negedge clk);
        end
        valid = 0;
        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysinfo.md
# sysinfo

Parametrised system-information peripheral on the CPU native bus (valid/address/wdata/wstrb/rdata/ready). It is the next generation of the single-word ID block. It exposes ID, version and feature words, a byte-writable scratch register, and a free-running uptime counter with a coherent 64-bit snapshot. It also drives a timed soft-reset request. It sits on the peripheral bus beside the other system peripherals. soft_rst_o goes to the SoC reset controller.

## Interface
- ID, 0: 32-bit system ID word.
- VERSION, 0: 32-bit hardware version word.
- FEATURES, 0: 32-bit feature bitmap word.
- ADDR_W, 3: word-address width; must be ≥3.
- CNT_W, 64: uptime counter width; must be 33..64.
- SRST_CYC, 16: soft-reset pulse length in cycles; must be 1..255.
- Data width is fixed at 32 bits (local constant DATA_W).
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- valid  in  1  request; held until ready.
- address  in  ADDR_W  word address.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes; all zero means read.
- rdata  out  32  read data; registered.
- ready  out  1  one-cycle acknowledge.
- soft_rst_o  out  1  soft-reset request to the reset controller.

## Operation
Register map (word address, access, contents):
- 0 ID, RO: ID.
- 1 VERSION, RO: VERSION.
- 2 FEATURES, RO: FEATURES.
- 3 SCRATCH, RW. Byte lanes are written per wstrb. Reset value 0.
- 4 UPTIME_LO, RO. Returns counter[31:0]. In the same cycle it latches counter[CNT_W-1:32] into the snapshot register.
- 5 UPTIME_HI, RO. Returns the snapshot, zero-extended. Does not sample the live counter. Snapshot reset value 0.
- 6 CTRL, WO; reads return 0.
  - Bit 0 = 1: clear the uptime counter.
  - Bit 1 = 1: start a soft-reset pulse.
  - Only byte lane 0 is honoured.
- 7 and above, unmapped: reads return 0, writes are ignored.

Access rules:
- A write to any RO register is ignored.
- A read to a WO or unmapped address returns 0.
- A write still produces ready, and rdata = 0 for that transaction.

Uptime counter:
- Increments every cycle after reset and wraps from 2^CNT_W−1 to 0.
- A clear takes effect on the cycle after acceptance: the counter reads 0 there, then increments.

Soft-reset FSM:
- States: IDLE and PULSE. An 8-bit down-counter holds the remaining cycles.
- IDLE→PULSE on an accepted CTRL write with bit1 = 1. The counter loads SRST_CYC.
- PULSE→IDLE when the counter reaches 1 and decrements.
- soft_rst_o = 1 exactly while in PULSE.
- A bit1 write while in PULSE reloads the counter to SRST_CYC, extending the pulse.
- The block does not reset itself from soft_rst_o; only rst resets it.

## Timing
- Acceptance cycle is any cycle with valid=1 and ready=0.
- All write side effects and the snapshot latch occur on the acceptance clock edge.
- ready = 1 on the cycle after acceptance, for exactly one cycle.
  - With valid held continuously, ready toggles, giving one transaction per 2 cycles.
  - A master must drop valid, or present a new request, after ready.
- Read data timing: rdata is valid in the ready cycle and holds that value until the next acceptance.
- UPTIME_LO data is the counter value at the acceptance edge, before any clear in the same cycle.
- A clear and a read of UPTIME_LO cannot coincide, since there is one transaction per acceptance. A clear occurring between LO and HI reads does not alter the snapshot.
- soft_rst_o rises on the cycle after the CTRL acceptance and stays high for SRST_CYC cycles.
- Reset values: ready=0, rdata=0, soft_rst_o=0, SCRATCH=0, snapshot=0, counter=0, FSM=IDLE.
- rst asserted mid-transaction or mid-pulse forces all of the above immediately. No ready is issued for the aborted request.

## Structure
- A shared header holds the register word-address constants (SYSINFO_ID … SYSINFO_CTRL) and the CTRL bit positions. Firmware includes the same header.
- One sub-module: sysinfo_uptime. It contains the CNT_W counter, clear input, snapshot latch input, lo/hi outputs, and its own async reset.
- The top level holds the decode, SCRATCH, the soft-reset FSM and the handshake.

## Test plan
- Reset, then read addresses 0/1/2 with ID=0xA5A5_0001, VERSION=0x0002_0100 and FEATURES=0x0000_000F. Required: those values appear in the ready cycle, ready pulses once per request, and the read of address 7 returns 0.
- Write SCRATCH with 0xDEADBEEF and wstrb=4'b1111, then 0x00000011 with wstrb=4'b0001, then read SCRATCH. Required: 0xDEADBE11. A write to ID is ignored, and a read of ID still returns 0xA5A5_0001.
- With CNT_W=40:
  - Force the counter near 0xFF_FFFF_FFFF, read LO, wait 10 cycles, read HI. Required: HI = 0xFF matches the LO sample.
  - Continue past wrap. Required: LO then HI give 0x0000_00xx / 0x00.
- Write CTRL=0x1, then read LO 2 cycles after ready. Required: a small value (≤4); the counter restarts from 0.
- Write CTRL=0x2 with SRST_CYC=16. Required: soft_rst_o high for exactly 16 cycles. A second bit1 write at pulse cycle 10 gives 26 high cycles in total. Asserting rst at cycle 5 drops soft_rst_o immediately.
- Hold valid high for 6 cycles to address 0. Required: ready pattern 0,1,0,1,0,1 and no stuck or double acknowledge.
